// File: rtl/conv_pkg.sv
// Shared definitions for the convolver output path: pixel width, frame geometry and the
// pooling stage state encoding.
package conv_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned IMG_W      = 98;
  localparam int unsigned IMG_H      = 98;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } pool_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// One-row store of horizontal pair maxima: synchronous write, combinational read so the
// odd-row merge completes in the same cycle as its input pixel.
module pool_line_buf #(
  parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = conv_pkg::IMG_W / 2,
  parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are meaningless until the even row of a block has been written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_maxpool2x2.sv
// Non-overlapping 2x2 max pooling over a row-major pixel stream, emitting a half-size
// frame with the same data/valid/running contract as its input.
module conv_maxpool2x2 #(
  parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int unsigned IMG_W      = conv_pkg::IMG_W,
  parameter int unsigned IMG_H      = conv_pkg::IMG_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  running_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  running_o,
  output logic                  abort_o
);
  import conv_pkg::*;

  localparam int unsigned HalfW = IMG_W / 2;
  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned AddrW = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_geom
    $error("conv_maxpool2x2: IMG_W and IMG_H must be even and at least 2");
  end

  pool_state_e           state_q, state_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  running_q, running_d;
  logic                  abort_q, abort_d;
  logic                  armed_q, armed_d;

  logic [DATA_WIDTH-1:0] hmax, lb_rdata, pooled;
  logic [AddrW-1:0]      lb_addr;
  logic                  lb_we;

  assign lb_addr = AddrW'(col_q >> 1);
  assign hmax    = (data_i > hold_q) ? data_i : hold_q;
  assign pooled  = (hmax > lb_rdata) ? hmax : lb_rdata;

  pool_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HalfW),
    .ADDR_W     (AddrW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    armed_d = armed_q;
    lb_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A frame only starts after running_i has been seen low since the last one ended.
        if (!running_i) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
          armed_d = 1'b0;
        end
      end
      StRun: begin
        if (!running_i) begin
          state_d = StIdle;
          abort_d = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end else if (valid_i) begin
          if (!col_q[0]) begin
            hold_d = data_i;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = pooled;
          end
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              state_d = StDrain;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    running_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      abort_q   <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      abort_q   <= abort_d;
      armed_q   <= armed_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign running_o = running_q;
  assign abort_o   = abort_q;

endmodule
